// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: data width, the canonical NOP
// encoding and the fetch queue entry layout.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  // One fetched instruction together with the word address it came from
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue between the fetch stage and decode. The head entry
// and its valid flag are read straight from state registers, so decode never
// sees a combinational path from its own ready input.
module fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fq_entry_t              wr_data,
  output fq_entry_t              head,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  fq_entry_t         r_mem [DEPTH];
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW:0]       r_count;
  logic              w_pop;

  // A pop only takes effect when there is something to consume
  assign w_pop = pop & (r_count != '0);

  // Storage, pointers and occupancy; flush empties the queue in one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= wr_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head       = r_mem[r_rd_ptr];
  assign head_valid = (r_count != '0);
  assign count      = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: presents the PC to synchronous instruction memory, tracks the
// in-flight read in the F1 register, queues returned instructions toward
// decode, and steers the PC for holds (queue full) and execute redirects.
module instruction_fetch_unit
  import core_pkg::*;
#(
  parameter int FQ_DEPTH = 4
) (
  input  logic            sysclk,
  input  logic            sysreset,
  input  logic [XLEN-1:0] pc_curr,
  output logic            pc_src,
  output logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_valid,
  input  logic            id_ready
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic            r_f1_valid;
  logic [XLEN-1:0] r_f1_pc;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_committed;
  logic            w_issue_ok;
  logic            w_push;
  fq_entry_t       w_wr_data;
  fq_entry_t       w_head;

  assign imem_addr = pc_curr;

  // The read in flight already owns a slot; a same-cycle pop earns no credit
  assign w_committed = w_count + {{(CW-1){1'b0}}, r_f1_valid};
  assign w_issue_ok  = (w_committed < CW'(FQ_DEPTH));

  // F1 register: remembers which address the returning read data belongs to
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      r_f1_valid <= 1'b0;
      r_f1_pc    <= '0;
    end else begin
      r_f1_valid <= w_issue_ok & ~ex_redirect;
      r_f1_pc    <= pc_curr;
    end
  end

  // A redirect kills the returning read as well as everything already queued
  assign w_push    = r_f1_valid & ~ex_redirect;
  assign w_wr_data = '{instr: imem_rdata, pc: r_f1_pc};

  fetch_queue #(
    .DEPTH(FQ_DEPTH)
  ) u_fetch_queue (
    .clk        (sysclk),
    .rst        (sysreset),
    .push       (w_push),
    .pop        (id_ready),
    .flush      (ex_redirect),
    .wr_data    (w_wr_data),
    .head       (w_head),
    .head_valid (id_valid),
    .count      (w_count)
  );

  assign id_instr = w_head.instr;
  assign id_pc    = w_head.pc;

  // PC steering: redirect beats hold, otherwise let the PC increment
  always_comb begin
    pc_src = 1'b0;
    pc_in  = '0;
    if (ex_redirect) begin
      pc_src = 1'b1;
      pc_in  = ex_target;
    end else if (!w_issue_ok) begin
      pc_src = 1'b1;
      pc_in  = pc_curr;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  import core_pkg::*;

  logic        sysclk = 1'b0;
  logic        sysreset;
  logic [31:0] pc_curr;
  logic        pc_src;
  logic [31:0] pc_in;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        id_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  logic [31:0] sb_q[$];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc   = '0;

  instruction_fetch_unit #(.FQ_DEPTH(4)) dut (
    .sysclk      (sysclk),
    .sysreset    (sysreset),
    .pc_curr     (pc_curr),
    .pc_src      (pc_src),
    .pc_in       (pc_in),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready)
  );

  always #5 sysclk = ~sysclk;

  // Program counter the unit controls
  always @(posedge sysclk) begin
    if (sysreset)    pc_curr <= '0;
    else if (pc_src) pc_curr <= pc_in;
    else             pc_curr <= pc_curr + 32'd1;
  end

  // Synchronous instruction memory: mem[a] = a*4 + 0x13
  always @(posedge sysclk) imem_rdata <= imem_addr * 32'd4 + 32'h13;

  function automatic void sb_restart(input logic [31:0] start);
    sb_q.delete();
    for (int i = 0; i < 256; i++) sb_q.push_back(start + 32'(i));
  endfunction

  // Scoreboard monitor: every accepted head must be the next program-order pc
  always @(negedge sysclk) begin
    logic [31:0] exp_pc;
    if (prev_hold) begin
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== prev_pc) begin
        n_fail++;
        $display("FAIL hold_stable: got valid=%b pc=%h want valid=1 pc=%h", id_valid, id_pc, prev_pc);
      end
    end
    if (id_valid === 1'b1 && id_ready === 1'b1) begin
      n_checks++;
      n_pops++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc=%h want no delivery", id_pc);
      end else begin
        exp_pc = sb_q.pop_front();
        if (id_pc !== exp_pc || id_instr !== exp_pc * 32'd4 + 32'h13) begin
          n_fail++;
          $display("FAIL sb_order: got pc=%h instr=%h want pc=%h instr=%h",
                   id_pc, id_instr, exp_pc, exp_pc * 32'd4 + 32'h13);
        end
      end
    end
    prev_hold = (id_valid === 1'b1) && !id_ready && !ex_redirect && !sysreset;
    prev_pc   = id_pc;
    if (sysreset)         sb_restart(32'd0);
    else if (ex_redirect) sb_restart(ex_target);
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // Hold reset two cycles, release just after an edge: the bench is then in cycle 0
  task automatic do_reset();
    sysreset    = 1'b1;
    ex_redirect = 1'b0;
    tick();
    tick();
    sysreset = 1'b0;
  endtask

  task automatic test_reset();
    sysreset    = 1'b1;
    ex_redirect = 1'b0;
    ex_target   = '0;
    id_ready    = 1'b1;
    tick();
    tick();
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", id_valid); end
    n_checks++; if (id_instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", id_instr); end
    n_checks++; if (id_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", id_pc); end
    n_checks++; if (pc_src !== 1'b0 || pc_in !== 32'd0) begin n_fail++; $display("FAIL reset_pcctl: got src=%b in=%h want src=0 in=0", pc_src, pc_in); end
    n_checks++; if (imem_addr !== pc_curr) begin n_fail++; $display("FAIL reset_imem_addr: got %h want %h", imem_addr, pc_curr); end
    sysreset = 1'b0;
  endtask

  task automatic test_stream();
    id_ready = 1'b1;
    do_reset();
    n_checks++; if (pc_src !== 1'b0) begin n_fail++; $display("FAIL stream_src_c0: got %b want 0", pc_src); end
    tick();
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL stream_latency_c1: got valid=%b want 0", id_valid); end
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(k) || id_instr !== 32'(k) * 32'd4 + 32'h13 || pc_src !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_k%0d: got valid=%b pc=%h instr=%h src=%b want valid=1 pc=%h instr=%h src=0",
                 k, id_valid, id_pc, id_instr, pc_src, 32'(k), 32'(k) * 32'd4 + 32'h13);
      end
    end
  endtask

  task automatic test_fill();
    logic [31:0] nexp;
    id_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    n_checks++;
    if (pc_src !== 1'b1 || pc_in !== pc_curr || pc_curr !== 32'd4 || id_valid !== 1'b1 || id_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL fill_hold: got src=%b in=%h pc=%h valid=%b head=%h want src=1 in=pc pc=4 valid=1 head=0",
               pc_src, pc_in, pc_curr, id_valid, id_pc);
    end
    repeat (3) tick();
    n_checks++; if (pc_curr !== 32'd4) begin n_fail++; $display("FAIL fill_pc_frozen: got %h want 4", pc_curr); end
    id_ready = 1'b1;
    nexp = 32'd0;
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== nexp) begin
        n_fail++;
        $display("FAIL fill_drain_%0d: got valid=%b pc=%h want valid=1 pc=%h", i, id_valid, id_pc, nexp);
      end
      nexp = nexp + 32'd1;
      tick();
    end
  endtask

  task automatic test_redirect();
    id_ready = 1'b1;
    do_reset();
    repeat (10) tick();
    ex_redirect = 1'b1;
    ex_target   = 32'h40;
    #1;
    n_checks++; if (pc_src !== 1'b1 || pc_in !== 32'h40) begin n_fail++; $display("FAIL redir_pcctl: got src=%b in=%h want src=1 in=40", pc_src, pc_in); end
    tick();
    ex_redirect = 1'b0;
    n_checks++; if (id_valid !== 1'b0 || pc_curr !== 32'h40) begin n_fail++; $display("FAIL redir_c11: got valid=%b pc=%h want valid=0 pc=40", id_valid, pc_curr); end
    tick();
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_c12: got valid=%b want 0", id_valid); end
    tick();
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== 32'h113) begin
      n_fail++;
      $display("FAIL redir_c13: got valid=%b pc=%h instr=%h want valid=1 pc=40 instr=113", id_valid, id_pc, id_instr);
    end
  endtask

  task automatic test_redirect_hold();
    id_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    n_checks++; if (pc_src !== 1'b1 || pc_in !== 32'd4) begin n_fail++; $display("FAIL rhold_pre: got src=%b in=%h want src=1 in=4", pc_src, pc_in); end
    ex_redirect = 1'b1;
    ex_target   = 32'h80;
    #1;
    n_checks++; if (pc_src !== 1'b1 || pc_in !== 32'h80) begin n_fail++; $display("FAIL rhold_priority: got src=%b in=%h want src=1 in=80", pc_src, pc_in); end
    tick();
    ex_redirect = 1'b0;
    id_ready    = 1'b1;
    n_checks++; if (id_valid !== 1'b0 || pc_curr !== 32'h80) begin n_fail++; $display("FAIL rhold_flush: got valid=%b pc=%h want valid=0 pc=80", id_valid, pc_curr); end
    tick();
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rhold_t2: got valid=%b want 0", id_valid); end
    tick();
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h80) begin n_fail++; $display("FAIL rhold_t3: got valid=%b pc=%h want valid=1 pc=80", id_valid, id_pc); end
  endtask

  task automatic test_reset_mid();
    id_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'd0) begin n_fail++; $display("FAIL rmid_pre: got valid=%b pc=%h want valid=1 pc=0", id_valid, id_pc); end
    sysreset = 1'b1;
    tick();
    n_checks++;
    if (id_valid !== 1'b0 || id_instr !== 32'd0 || id_pc !== 32'd0 || pc_curr !== 32'd0) begin
      n_fail++;
      $display("FAIL rmid_clear: got valid=%b instr=%h pc=%h pc_curr=%h want all 0", id_valid, id_instr, id_pc, pc_curr);
    end
    sysreset = 1'b0;
    id_ready = 1'b1;
    tick();
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_c1: got valid=%b want 0", id_valid); end
    tick();
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'd0) begin n_fail++; $display("FAIL rmid_restart: got valid=%b pc=%h want valid=1 pc=0", id_valid, id_pc); end
  endtask

  task automatic test_random();
    int pops_before;
    int since_redir;
    id_ready = 1'b1;
    do_reset();
    pops_before = n_pops;
    since_redir = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      if (!ex_redirect && (($urandom_range(0, 15) == 0) || since_redir >= 120)) begin
        ex_redirect = 1'b1;
        ex_target   = 32'($urandom_range(0, 1023));
        since_redir = 0;
      end else begin
        ex_redirect = 1'b0;
        since_redir++;
      end
      tick();
    end
    ex_redirect = 1'b0;
    id_ready    = 1'b1;
    repeat (8) tick();
    n_checks++;
    if (n_pops - pops_before < 150) begin
      n_fail++;
      $display("FAIL random_progress: got %0d deliveries want at least 150", n_pops - pops_before);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    sysreset    = 1'b1;
    ex_redirect = 1'b0;
    ex_target   = '0;
    id_ready    = 1'b0;
    test_reset();
    test_stream();
    test_fill();
    test_redirect();
    test_redirect_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
